// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative signed/unsigned multiply and divide with a start/busy/done handshake
module mul_div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic is_div, sa, sb, zero;
  logic [DATA_W-1:0] b, rem, m1, m2, quo, rres;
  logic [2*DATA_W-1:0] acc, prod;
  logic [DATA_W:0] msum, shifted, diff;
  logic s1neg, s2neg, last, div0;
  assign s1neg   = ~op_i[0] & src1_i[DATA_W-1];
  assign s2neg   = ~op_i[0] & src2_i[DATA_W-1];
  assign m1      = s1neg ? -src1_i : src1_i;
  assign m2      = s2neg ? -src2_i : src2_i;
  assign div0    = op_i[1] && src2_i == '0;
  assign last    = cnt == CNT_W'(DATA_W-1);
  assign msum    = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, b} : '0);
  assign shifted = {rem, acc[DATA_W-1]};
  assign diff    = shifted - {1'b0, b};
  assign prod    = (sa ^ sb) ? -acc : acc;
  assign quo     = (sa ^ sb) ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
  assign rres    = sa ? -rem : rem;
  assign busy_o  = state != IDLE;
  // state register
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next-state: divide by zero skips the iteration phase
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_i) state_nx = div0 ? FIX : CALC;
      CALC:    if (last) state_nx = FIX;
      default: state_nx = IDLE;
    endcase
  end
  // datapath: operand latch, one bit per CALC cycle, sign fix and result register
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0; is_div <= 1'b0; sa <= 1'b0; sb <= 1'b0; zero <= 1'b0;
      b <= '0; rem <= '0; acc <= '0; done_o <= 1'b0; hi_o <= '0; lo_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          cnt    <= '0;
          rem    <= '0;
          is_div <= op_i[1];
          sa     <= s1neg;
          sb     <= s2neg;
          zero   <= div0;
          b      <= op_i[1] ? m2 : m1;
          acc    <= div0 ? {src1_i, {DATA_W{1'b1}}} : {{DATA_W{1'b0}}, op_i[1] ? m1 : m2};
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            rem                <= diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
            acc[DATA_W-1:0]    <= {acc[DATA_W-2:0], ~diff[DATA_W]};
          end else acc <= {msum, acc[DATA_W-1:1]};
        end
        default: begin
          done_o       <= 1'b1;
          {hi_o, lo_o} <= zero ? acc : is_div ? {rres, quo} : prod;
        end
      endcase
    end
endmodule
